// File: rtl/enet_nios_divider.sv
// rtl/enet_nios_divider.sv - multi-cycle restoring integer divider for the Nios custom instruction
//
// One division in flight at a time. A single restoring step is made per
// enabled clock, so a WIDTH-bit divide takes WIDTH+2 enabled cycles from the
// accepted start to the done pulse.
//
// Ports:
//   clk          sole clock, rising edge
//   reset_n      synchronous active-low reset, overrides clk_en
//   clk_en       global enable; low freezes every register
//   start        request, accepted in IDLE or DONE
//   n            mode: 0 signed quo, 1 signed rem, 2 unsigned quo, 3 unsigned rem
//   dataa        dividend
//   datab        divisor
//   done         one-enabled-cycle completion pulse
//   result       selected quotient or remainder, held until the next FIX
//   div_by_zero  divisor was zero, valid with done and held with result

module enet_nios_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic [1:0]       n,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [1:0]       mode;
  logic [WIDTH:0]   divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             dz_pend;

  // operand preparation for a new request
  logic             signed_req;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   b_mag;

  // one restoring step
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // sign fix-up and selection
  logic             signed_op;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] res_fix;

  always_comb begin
    signed_req = ~n[1];
    a_neg      = signed_req & dataa[WIDTH-1];
    b_neg      = signed_req & datab[WIDTH-1];
    // The WIDTH-bit negation of the most-negative value yields 2^(WIDTH-1),
    // which is exactly its magnitude when read as unsigned.
    a_mag      = a_neg ? (~dataa + 1'b1) : dataa;
    // Divisor is sign-extended by one bit so its magnitude is exact.
    b_ext      = {b_neg, datab};
    b_mag      = b_neg ? (~b_ext + 1'b1) : b_ext;
  end

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    fits    = (shifted >= divisor);
    // When the trial subtract succeeds the difference is below the divisor,
    // so the low WIDTH bits of the modular subtraction are the full answer.
    diff    = shifted[WIDTH-1:0] - divisor[WIDTH-1:0];
  end

  always_comb begin
    signed_op = ~mode[1];
    q_fix     = (signed_op & neg_q) ? (~quo + 1'b1) : quo;
    r_fix     = (signed_op & neg_r) ? (~rem + 1'b1) : rem;
    res_fix   = mode[0] ? r_fix : q_fix;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (cnt == '0) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = start ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode        <= '0;
      divisor     <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_pend     <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode    <= n;
            divisor <= b_mag;
            rem     <= '0;
            quo     <= a_mag;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            // The visible flag only moves at FIX so it stays paired with result.
            dz_pend <= (datab == '0);
            cnt     <= CW'(WIDTH - 1);
          end
        end
        S_RUN: begin
          rem <= fits ? diff : shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], fits};
          cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          result      <= res_fix;
          div_by_zero <= dz_pend;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enet_nios_divider.sv
// tb/tb_enet_nios_divider.sv - directed vector bench for enet_nios_divider at WIDTH 32 and 8

module tb_enet_nios_divider;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b1;

  logic        start = 1'b0;
  logic [1:0]  n = '0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic        done32;
  logic [31:0] result32;
  logic        dz32;

  logic        start8 = 1'b0;
  logic [1:0]  n8 = '0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        done8;
  logic [7:0]  result8;
  logic        dz8;

  int cmp_total = 0;
  int cmp_fail  = 0;

  enet_nios_divider #(.WIDTH(32)) u_div32 (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_en      (clk_en),
    .start       (start),
    .n           (n),
    .dataa       (dataa),
    .datab       (datab),
    .done        (done32),
    .result      (result32),
    .div_by_zero (dz32)
  );

  enet_nios_divider #(.WIDTH(8)) u_div8 (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_en      (clk_en),
    .start       (start8),
    .n           (n8),
    .dataa       (a8),
    .datab       (b8),
    .done        (done8),
    .result      (result8),
    .div_by_zero (dz8)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          w8;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_dz;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_total++;
    if (act !== exp) begin
      cmp_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one request and waits for done; lat counts enabled cycles with the
  // accepting cycle as 0, and is -1 when done never arrives.
  task automatic do_op(input bit w8, input logic [1:0] mode, input logic [31:0] a,
                       input logic [31:0] b, input bit rnd,
                       output logic [31:0] res, output logic dz, output int lat);
    int   guard;
    logic dn;
    @(negedge clk);
    clk_en = 1'b1;
    if (w8) begin
      start8 = 1'b1; n8 = mode; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start = 1'b1; n = mode; dataa = a; datab = b;
    end
    @(posedge clk); #1;
    start  = 1'b0;
    start8 = 1'b0;
    lat    = 1;
    guard  = 0;
    dn     = w8 ? done8 : done32;
    while (!dn && guard < 400) begin
      clk_en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (clk_en) lat++;
      guard++;
      dn = w8 ? done8 : done32;
    end
    res = w8 ? {24'h0, result8} : result32;
    dz  = w8 ? dz8 : dz32;
    if (!dn) lat = -1;
  endtask

  initial begin
    logic [31:0] res;
    logic        dz;
    int          lat;
    int          cnt;

    vecs[0]  = '{1'b0, 2'd0, 32'd100,       32'd7,         32'd14,        1'b0};
    vecs[1]  = '{1'b0, 2'd1, 32'd100,       32'd7,         32'd2,         1'b0};
    vecs[2]  = '{1'b0, 2'd0, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  1'b0};
    vecs[3]  = '{1'b0, 2'd1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFFE,  1'b0};
    vecs[4]  = '{1'b0, 2'd0, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  1'b0};
    vecs[5]  = '{1'b0, 2'd1, 32'd100,       32'hFFFFFFF9,  32'd2,         1'b0};
    vecs[6]  = '{1'b0, 2'd0, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0};
    vecs[7]  = '{1'b0, 2'd1, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b0};
    vecs[8]  = '{1'b0, 2'd2, 32'hFFFFFFFF,  32'd2,         32'h7FFFFFFF,  1'b0};
    vecs[9]  = '{1'b0, 2'd3, 32'hFFFFFFFF,  32'd2,         32'd1,         1'b0};
    vecs[10] = '{1'b0, 2'd2, 32'd5,         32'd0,         32'hFFFFFFFF,  1'b1};
    vecs[11] = '{1'b0, 2'd3, 32'd5,         32'd0,         32'd5,         1'b1};
    vecs[12] = '{1'b0, 2'd0, 32'hFFFFFF9C,  32'd0,         32'd1,         1'b1};
    vecs[13] = '{1'b0, 2'd0, 32'd100,       32'd0,         32'hFFFFFFFF,  1'b1};
    vecs[14] = '{1'b0, 2'd1, 32'hFFFFFF9C,  32'd0,         32'hFFFFFF9C,  1'b1};
    vecs[15] = '{1'b0, 2'd0, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        1'b0};
    vecs[16] = '{1'b0, 2'd1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'hFFFFFFFE,  1'b0};
    vecs[17] = '{1'b0, 2'd2, 32'hF0000000,  32'h80000000,  32'd1,         1'b0};
    vecs[18] = '{1'b0, 2'd3, 32'hF0000000,  32'h80000000,  32'h70000000,  1'b0};
    vecs[19] = '{1'b1, 2'd2, 32'd200,       32'd3,         32'd66,        1'b0};
    vecs[20] = '{1'b1, 2'd3, 32'd200,       32'd3,         32'd2,         1'b0};
    vecs[21] = '{1'b1, 2'd0, 32'h80,        32'hFF,        32'h80,        1'b0};
    vecs[22] = '{1'b1, 2'd1, 32'h80,        32'hFF,        32'h00,        1'b0};
    vecs[23] = '{1'b1, 2'd2, 32'd200,       32'd0,         32'hFF,        1'b1};
    vecs[24] = '{1'b1, 2'd0, 32'hF9,        32'd2,         32'hFD,        1'b0};
    vecs[25] = '{1'b1, 2'd1, 32'hF9,        32'd2,         32'hFF,        1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_result32", result32, 32'h0);
    check("reset_done32", {31'h0, done32}, 32'h0);
    check("reset_dz32", {31'h0, dz32}, 32'h0);
    check("reset_result8", {24'h0, result8}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // directed table with full enable; consecutive ops start in the DONE cycle
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].w8, vecs[i].mode, vecs[i].a, vecs[i].b, 1'b0, res, dz, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_dz", i), {31'h0, dz}, {31'h0, vecs[i].exp_dz});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].w8 ? 32'd10 : 32'd34);
    end

    // same table with clk_en toggled pseudo-randomly
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].w8, vecs[i].mode, vecs[i].a, vecs[i].b, 1'b1, res, dz, lat);
      check($sformatf("rnd%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("rnd%0d_dz", i), {31'h0, dz}, {31'h0, vecs[i].exp_dz});
      check($sformatf("rnd%0d_latency", i), lat, vecs[i].w8 ? 32'd10 : 32'd34);
    end

    // done holds across disabled cycles and drops after one enabled cycle
    do_op(1'b0, 2'd0, 32'd100, 32'd7, 1'b0, res, dz, lat);
    @(negedge clk);
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("done_held_disabled", {31'h0, done32}, 32'h1);
    check("result_held_disabled", result32, 32'd14);
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk); #1;
    check("done_drops", {31'h0, done32}, 32'h0);
    check("result_held_idle", result32, 32'd14);

    // start during RUN and FIX with other operands is ignored
    @(negedge clk);
    start = 1'b1; n = 2'd1; dataa = 32'd100; datab = 32'd7;
    @(posedge clk); #1;
    lat = 1;
    while (!done32 && lat < 400) begin
      start = ((lat >= 5 && lat <= 8) || lat == 33);
      if (start) begin
        n = 2'd2; dataa = 32'd1000; datab = 32'd3;
      end
      if (lat == 20) check("result_held_in_run", result32, 32'd14);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("ignored_start_latency", lat, 32'd34);
    check("ignored_start_result", result32, 32'd2);
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) cnt++;
    end
    check("ignored_start_no_extra_done", cnt, 32'd0);

    // reset in RUN cycle 10 aborts the operation and clears the outputs
    do_op(1'b0, 2'd2, 32'd5, 32'd0, 1'b0, res, dz, lat);
    check("pre_reset_dz", {31'h0, dz}, 32'h1);
    @(negedge clk);
    start = 1'b1; n = 2'd0; dataa = 32'd100; datab = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_result", result32, 32'h0);
    check("midreset_done", {31'h0, done32}, 32'h0);
    check("midreset_dz", {31'h0, dz32}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) cnt++;
    end
    check("midreset_no_done", cnt, 32'd0);
    do_op(1'b0, 2'd0, 32'hFFFFFF9C, 32'd7, 1'b0, res, dz, lat);
    check("post_reset_result", res, 32'hFFFFFFF2);
    check("post_reset_latency", lat, 32'd34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_total, cmp_fail);
    $finish;
  end

endmodule
